// File: rtl/result_collector_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : Definitions (package)                                  |
// | Brief   : Shared types for the processor-control result path.    |
// | Rev     : 1.0  initial result collector types                    |
// +------------------------------------------------------------------+
package Definitions;

  localparam int NUM_PROCESSORS = 4;
  localparam int MAX_N          = 8;
  localparam int RESULT_W       = 16;

  typedef logic [RESULT_W-1:0] result_word_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DRAIN   = 2'd2
  } collector_state_e;

  typedef struct packed {
    logic [3:0] count;
    logic       full;
    logic       empty;
    logic       overflow;
    logic       frame_done;
  } RESULT_COLLECTOR_STATUS;

  typedef struct packed {
    logic       push_result;
    logic [1:0] processor_number;
    logic       rst_FIFO_out;
  } PROCESSORS_CONTROL_SIGNALS;

  // Out-of-range frame lengths collapse to a full buffer.
  function automatic logic [3:0] clamp_len(input logic [3:0] n, input logic [3:0] depth);
    return ((n == 4'd0) || (n > depth)) ? depth : n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/result_collector_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : result_fifo                                            |
// | Brief   : Synchronous FIFO of {last, data} with registered flags.|
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
module result_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_last,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              rd_valid,
  output logic [3:0]        count,
  output logic              full,
  output logic              empty
);

  localparam int         c_aw    = $clog2(DEPTH);
  localparam logic [3:0] c_depth = 4'(DEPTH);

  logic [DATA_W:0]   r_mem [DEPTH];
  logic [c_aw-1:0]   r_wr_ptr;
  logic [c_aw-1:0]   r_rd_ptr;
  logic [3:0]        r_count;
  logic              r_full;
  logic              r_empty;
  logic [3:0]        w_count_nxt;
  logic              w_push;
  logic              w_pop;

  // A full buffer refuses the write even if a pop frees a slot this cycle.
  assign w_push = wr_en && !r_full;
  assign w_pop  = rd_ready && !r_empty;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)
      w_count_nxt = r_count + 4'd1;
    else if (!w_push && w_pop)
      w_count_nxt = r_count - 4'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_aw'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_aw'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == c_depth);
      r_empty <= (w_count_nxt == 4'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !clear)
      r_mem[r_wr_ptr] <= {wr_last, wr_data};
  end

  assign rd_valid = !r_empty;
  assign rd_data  = r_empty ? '0   : r_mem[r_rd_ptr][DATA_W-1:0];
  assign rd_last  = r_empty ? 1'b0 : r_mem[r_rd_ptr][DATA_W];
  assign count    = r_count;
  assign full     = r_full;
  assign empty    = r_empty;

endmodule
`default_nettype wire

// File: rtl/result_collector.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : result_collector                                       |
// | Brief   : Captures selected PE results into a framed output FIFO.|
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
module result_collector
  import Definitions::*;
#(
  parameter int DATA_W = RESULT_W,
  parameter int DEPTH  = MAX_N
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             rst_fifo_out,
  input  logic                             push_result,
  input  logic [1:0]                       processor_number,
  input  logic [NUM_PROCESSORS*DATA_W-1:0] proc_result,
  input  logic [3:0]                       n_len,
  output logic [DATA_W-1:0]                out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             out_last,
  output logic [3:0]                       count,
  output logic                             full,
  output logic                             empty,
  output logic                             overflow,
  output logic                             frame_done
);

  localparam logic [1:0] S_IDLE    = ST_IDLE;
  localparam logic [1:0] S_COLLECT = ST_COLLECT;
  localparam logic [1:0] S_DRAIN   = ST_DRAIN;
  localparam logic [3:0] c_depth   = 4'(DEPTH);

  PROCESSORS_CONTROL_SIGNALS w_ctrl;
  RESULT_COLLECTOR_STATUS    w_status;

  logic [DATA_W-1:0] w_lane [NUM_PROCESSORS];
  logic [DATA_W-1:0] w_sel;
  logic [1:0]        r_state;
  logic [3:0]        r_n;
  logic [3:0]        r_wr_cnt;
  logic              r_overflow;
  logic              r_frame_done;
  logic [3:0]        w_n_new;
  logic              w_len_bad;
  logic [3:0]        w_cnt_inc;
  logic              w_accept;
  logic              w_wr_last;
  logic              w_ovf_set;
  logic              w_pop_last;
  logic [3:0]        w_fifo_count;
  logic              w_fifo_full;
  logic              w_fifo_empty;

  assign w_ctrl = '{push_result:      push_result,
                    processor_number: processor_number,
                    rst_FIFO_out:     rst_fifo_out};

  for (genvar gi = 0; gi < NUM_PROCESSORS; gi++) begin : g_lane
    assign w_lane[gi] = proc_result[gi*DATA_W +: DATA_W];
  end
  assign w_sel = w_lane[w_ctrl.processor_number];

  assign w_n_new    = clamp_len(n_len, c_depth);
  assign w_len_bad  = (n_len == 4'd0) || (n_len > c_depth);
  assign w_cnt_inc  = r_wr_cnt + 4'd1;
  assign w_pop_last = out_valid && out_ready && out_last;
  assign w_accept   = w_ctrl.push_result && !w_fifo_full && (r_state != S_DRAIN);

  always_comb begin
    w_wr_last = 1'b0;
    w_ovf_set = 1'b0;
    if (w_ctrl.push_result) begin
      if (w_fifo_full || (r_state == S_DRAIN))
        w_ovf_set = 1'b1;
      else if (r_state == S_IDLE)
        w_ovf_set = w_len_bad;
    end
    if (r_state == S_IDLE)
      w_wr_last = (w_n_new == 4'd1);
    else
      w_wr_last = (w_cnt_inc == r_n);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_n          <= '0;
      r_wr_cnt     <= '0;
      r_overflow   <= 1'b0;
      r_frame_done <= 1'b0;
    end else if (w_ctrl.rst_FIFO_out) begin
      r_state      <= S_IDLE;
      r_n          <= '0;
      r_wr_cnt     <= '0;
      r_overflow   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_pop_last;
      if (w_ovf_set)
        r_overflow <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_n      <= w_n_new;
            r_wr_cnt <= 4'd1;
            r_state  <= (w_n_new == 4'd1) ? S_DRAIN : S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (w_accept) begin
            r_wr_cnt <= w_cnt_inc;
            if (w_cnt_inc == r_n)
              r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_pop_last)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  result_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .clear    (w_ctrl.rst_FIFO_out),
    .wr_en    (w_accept),
    .wr_data  (w_sel),
    .wr_last  (w_wr_last),
    .rd_ready (out_ready),
    .rd_data  (out_data),
    .rd_last  (out_last),
    .rd_valid (out_valid),
    .count    (w_fifo_count),
    .full     (w_fifo_full),
    .empty    (w_fifo_empty)
  );

  assign w_status = '{count:      w_fifo_count,
                      full:       w_fifo_full,
                      empty:      w_fifo_empty,
                      overflow:   r_overflow,
                      frame_done: r_frame_done};

  assign count      = w_status.count;
  assign full       = w_status.full;
  assign empty      = w_status.empty;
  assign overflow   = w_status.overflow;
  assign frame_done = w_status.frame_done;

endmodule
`default_nettype wire
